pipe_stall_ctrl: RTL

//  Central pipeline sequencer for the 5-stage MIPS32 core. Arbitrates stall requests from IF/ID/EX/MEM

---
 rtl/pipe_stall_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: arbitrates stall requests into the 6-bit stall vector, issues exception
// flushes with a redirect PC, masks stale ID/EX requests after a flush and breaks hung bus stalls.
module pipe_stall_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned FLUSH_MASK     = 1,
  parameter logic [31:0] EXC_BASE       = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        buserr_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {StRun, StStall, StFlush, StBuserr} state_e;

  state_e      state_q, state_d;
  logic [31:0] wdog_q, wdog_d;
  logic [31:0] mask_cnt_q, mask_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic       req_id, req_ex;
  logic       bus_win, raw_any;
  logic [5:0] stall_vec;

  // Request arbitration; ID/EX requests are stale while the post-flush mask is active.
  always_comb begin
    req_id    = stallreq_id & (state_q != StFlush);
    req_ex    = stallreq_ex & (state_q != StFlush);
    raw_any   = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;
    bus_win   = 1'b0;
    stall_vec = 6'b000000;
    if (stallreq_mem) begin
      stall_vec = 6'b011111;
      bus_win   = 1'b1;
    end else if (req_ex) begin
      stall_vec = 6'b001111;
    end else if (req_id) begin
      stall_vec = 6'b000111;
    end else if (stallreq_if) begin
      stall_vec = 6'b000111;
      bus_win   = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    mask_cnt_d = mask_cnt_q;
    stall      = 6'b000000;
    flush      = 1'b0;
    new_pc     = 32'h0;
    buserr_o   = 1'b0;

    if (state_q == StBuserr) begin
      // Bus-error cycle ignores everything, including a coincident exception.
      buserr_o = 1'b1;
      wdog_d   = 32'h0;
      state_d  = StRun;
    end else if (excepttype_i != 32'h0) begin
      flush      = 1'b1;
      wdog_d     = 32'h0;
      mask_cnt_d = 32'(FLUSH_MASK);
      state_d    = StFlush;
      case (excepttype_i)
        32'h0000_0001: new_pc = EXC_BASE;
        32'h0000_000e: new_pc = cp0_epc_i;
        default:       new_pc = EXC_BASE + 32'h20;
      endcase
    end else if (state_q == StFlush) begin
      stall  = stall_vec;
      wdog_d = 32'h0;
      if (mask_cnt_q != 32'h0) begin
        mask_cnt_d = mask_cnt_q - 32'h1;
      end
      if (mask_cnt_q <= 32'h1) begin
        state_d = raw_any ? StStall : StRun;
      end
    end else begin
      stall  = stall_vec;
      wdog_d = bus_win ? wdog_q + 32'h1 : 32'h0;
      if (bus_win && (wdog_q == 32'(TIMEOUT_CYCLES - 1))) begin
        state_d = StBuserr;
      end else begin
        state_d = (stall_vec != 6'b000000) ? StStall : StRun;
      end
    end

    if (rst) begin
      stall    = 6'b000000;
      flush    = 1'b0;
      new_pc   = 32'h0;
      buserr_o = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall != 6'b000000) begin
      stall_cnt_d = stall_cnt_q + 32'h1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wdog_q      <= 32'h0;
      mask_cnt_q  <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      mask_cnt_q  <= mask_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
